// File: rtl/i2c_reg_bridge_pkg.sv
// Shared types and constants for the I2C register bridge: FSM encodings,
// special addresses and the range check used by both read and write paths.
package i2c_reg_bridge_pkg;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] RD_OOR_VALUE = 8'hFF;

  // True when the pointer selects a real R/W register (1..num_regs).
  function automatic logic addr_in_range(input logic [7:0] addr, input logic [7:0] num_regs);
    return (addr != ADDR_ID) && (addr <= num_regs);
  endfunction

endpackage

// File: rtl/i2c_reg_file.sv
// NUM_REGS x 8-bit register bank, addresses 1..NUM_REGS, one write port,
// one combinational read port (unmapped addresses read 0) and a flattened view.
module i2c_reg_file #(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [7:0]            waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [7:0]            raddr_i,
  output logic [7:0]            rdata_o,
  output logic [NUM_REGS*8-1:0] regs_o
);

  logic [NUM_REGS*8-1:0] regs_q;

  // Register storage with single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else if (we_i) begin
      for (int k = 1; k <= NUM_REGS; k++) begin
        if (waddr_i == 8'(k)) begin
          regs_q[8*k-1 -: 8] <= wdata_i;
        end
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    rdata_o = 8'h00;
    for (int k = 1; k <= NUM_REGS; k++) begin
      if (raddr_i == 8'(k)) begin
        rdata_o = regs_q[8*k-1 -: 8];
      end else begin
        rdata_o = rdata_o;
      end
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/i2c_reg_bridge.sv
// Turns the I2C target byte stream into a byte-addressed register bank with an
// auto-incrementing pointer; first byte after START sets the pointer.
module i2c_reg_bridge
  import i2c_reg_bridge_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'h66
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  tx_req_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_stb_o,
  output logic [7:0]            wr_addr_o,
  output logic                  err_o
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       wr_stb_q, wr_stb_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic       err_q, err_d;
  logic       we_s;
  logic [7:0] rdata_s;
  logic       ptr_ok_s;

  assign ptr_ok_s = addr_in_range(ptr_q, NUM_REGS_B);

  i2c_reg_file #(.NUM_REGS(NUM_REGS)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_s),
    .waddr_i (ptr_q),
    .wdata_i (rx_data_i),
    .raddr_i (ptr_q),
    .rdata_o (rdata_s),
    .regs_o  (regs_o)
  );

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ADDR;
      ptr_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
    end
  end

  // Event decode: start beats rx, rx beats tx; a dropped event flags an error.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    err_d      = err_q;
    we_s       = 1'b0;
    if (start_i) begin
      state_d = ST_ADDR;
      err_d   = rx_valid_i | tx_req_i;
    end else if (rx_valid_i) begin
      if (tx_req_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
      case (state_q)
        ST_ADDR: begin
          ptr_d   = rx_data_i;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          ptr_d = ptr_q + 8'h01;
          if (ptr_ok_s) begin
            we_s      = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_ADDR;
        end
      endcase
    end else if (tx_req_i) begin
      tx_valid_d = 1'b1;
      ptr_d      = ptr_q + 8'h01;
      if (ptr_q == ADDR_ID) begin
        tx_data_d = ID_VALUE;
      end else if (ptr_ok_s) begin
        tx_data_d = rdata_s;
      end else begin
        tx_data_d = RD_OOR_VALUE;
        err_d     = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign wr_stb_o   = wr_stb_q;
  assign wr_addr_o  = wr_addr_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed testbench for i2c_reg_bridge with NUM_REGS=8, ID_VALUE=8'h66.
module tb_i2c_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        tx_req_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic [63:0] regs_o;
  logic        wr_stb_o;
  logic [7:0]  wr_addr_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_regs;

  i2c_reg_bridge #(.NUM_REGS(8), .ID_VALUE(8'h66)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .tx_req_i(tx_req_i), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .regs_o(regs_o), .wr_stb_o(wr_stb_o),
    .wr_addr_o(wr_addr_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; returns 1 time unit after the capturing edge.
  task automatic cyc(input logic s, input logic rv, input logic [7:0] d, input logic tr);
    @(negedge clk);
    start_i = s; rx_valid_i = rv; rx_data_i = d; tx_req_i = tr;
    @(posedge clk);
    #1;
    start_i = 1'b0; rx_valid_i = 1'b0; tx_req_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (regs_o !== 64'h0) begin n_bad++; $display("FAIL reset_regs: got %h want %h", regs_o, 64'h0); end
    n_cmp++; if ({tx_data_o, tx_valid_o, wr_stb_o, wr_addr_o, err_o} !== 19'h0) begin n_bad++;
      $display("FAIL reset_outs: got txd=%h txv=%b stb=%b wa=%h err=%b want all 0", tx_data_o, tx_valid_o, wr_stb_o, wr_addr_o, err_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_burst();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    n_cmp++; if (wr_stb_o !== 1'b0) begin n_bad++; $display("FAIL wb_ptr_nostb: got %b want 0", wr_stb_o); end
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    n_cmp++; if ({wr_stb_o, wr_addr_o} !== {1'b1, 8'h02}) begin n_bad++; $display("FAIL wb_stb1: got %b/%h want 1/02", wr_stb_o, wr_addr_o); end
    cyc(1'b0, 1'b1, 8'hBB, 1'b0);
    n_cmp++; if ({wr_stb_o, wr_addr_o} !== {1'b1, 8'h03}) begin n_bad++; $display("FAIL wb_stb2: got %b/%h want 1/03", wr_stb_o, wr_addr_o); end
    exp_regs[15:8] = 8'hAA; exp_regs[23:16] = 8'hBB;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (wr_stb_o !== 1'b0) begin n_bad++; $display("FAIL wb_stb_end: got %b want 0", wr_stb_o); end
    n_cmp++; if (regs_o !== exp_regs) begin n_bad++; $display("FAIL wb_regs: got %h want %h", regs_o, exp_regs); end
    // Pointer kept across START: a read now hits reg4 (0x00) and advances to 5.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({tx_valid_o, tx_data_o} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL wb_ptr4: got %b/%h want 1/00", tx_valid_o, tx_data_o); end
  endtask

  task automatic test_read_back();
    logic [7:0] exp_rd [3];
    int pulses;
    exp_rd[0] = 8'hAA; exp_rd[1] = 8'hBB; exp_rd[2] = 8'h00;
    pulses = 0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      pulses += int'(tx_valid_o);
      n_cmp++; if ({tx_valid_o, tx_data_o} !== {1'b1, exp_rd[i]}) begin n_bad++;
        $display("FAIL rd_byte%0d: got %b/%h want 1/%h", i, tx_valid_o, tx_data_o, exp_rd[i]); end
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      pulses += int'(tx_valid_o);
      n_cmp++; if ({tx_valid_o, tx_data_o} !== {1'b0, exp_rd[i]}) begin n_bad++;
        $display("FAIL rd_hold%0d: got %b/%h want 0/%h", i, tx_valid_o, tx_data_o, exp_rd[i]); end
    end
    n_cmp++; if (pulses !== 3) begin n_bad++; $display("FAIL rd_pulses: got %0d want 3", pulses); end
  endtask

  task automatic test_id_oor();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({tx_valid_o, tx_data_o, err_o} !== {1'b1, 8'h66, 1'b0}) begin n_bad++;
      $display("FAIL id_read: got %b/%h err=%b want 1/66 err=0", tx_valid_o, tx_data_o, err_o); end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h09, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({tx_valid_o, tx_data_o, err_o} !== {1'b1, 8'hFF, 1'b1}) begin n_bad++;
      $display("FAIL oor_read: got %b/%h err=%b want 1/ff err=1", tx_valid_o, tx_data_o, err_o); end
    cyc(1'b0, 1'b1, 8'h55, 1'b0);
    n_cmp++; if ({wr_stb_o, err_o} !== 2'b01) begin n_bad++; $display("FAIL oor_write: got stb=%b err=%b want 0/1", wr_stb_o, err_o); end
    n_cmp++; if (regs_o !== exp_regs) begin n_bad++; $display("FAIL oor_regs: got %h want %h", regs_o, exp_regs); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL wrap_errclr: got %b want 0", err_o); end
    cyc(1'b0, 1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({tx_data_o, err_o} !== {8'hFF, 1'b1}) begin n_bad++; $display("FAIL wrap_ff: got %h err=%b want ff err=1", tx_data_o, err_o); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({tx_valid_o, tx_data_o, err_o} !== {1'b1, 8'h66, 1'b1}) begin n_bad++;
      $display("FAIL wrap_id: got %b/%h err=%b want 1/66 err=1", tx_valid_o, tx_data_o, err_o); end
  endtask

  task automatic test_collisions();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h03, 1'b0);
    cyc(1'b0, 1'b1, 8'h5A, 1'b1);
    exp_regs[23:16] = 8'h5A;
    n_cmp++; if ({wr_stb_o, wr_addr_o, tx_valid_o, err_o} !== {1'b1, 8'h03, 1'b0, 1'b1}) begin n_bad++;
      $display("FAIL col_rxtx: got stb=%b wa=%h txv=%b err=%b want 1/03/0/1", wr_stb_o, wr_addr_o, tx_valid_o, err_o); end
    n_cmp++; if (regs_o !== exp_regs) begin n_bad++; $display("FAIL col_regs: got %h want %h", regs_o, exp_regs); end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL col_errclr: got %b want 0", err_o); end
    cyc(1'b1, 1'b1, 8'h07, 1'b0);
    n_cmp++; if ({wr_stb_o, err_o} !== 2'b01) begin n_bad++; $display("FAIL col_start_rx: got stb=%b err=%b want 0/1", wr_stb_o, err_o); end
    // Still in ADDR: this byte is the pointer, not a write to reg7.
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    n_cmp++; if (wr_stb_o !== 1'b0) begin n_bad++; $display("FAIL col_addr_state: got stb=%b want 0", wr_stb_o); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (tx_data_o !== 8'hAA) begin n_bad++; $display("FAIL col_ptr: got %h want aa", tx_data_o); end
  endtask

  task automatic test_reset_mid_burst();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h01, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    n_cmp++; if (regs_o[7:0] !== 8'h11) begin n_bad++; $display("FAIL rm_write: got %h want 11", regs_o[7:0]); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    exp_regs = 64'h0;
    n_cmp++; if (regs_o !== exp_regs) begin n_bad++; $display("FAIL rm_regs: got %h want %h", regs_o, exp_regs); end
    n_cmp++; if ({tx_data_o, tx_valid_o, wr_stb_o, wr_addr_o, err_o} !== 19'h0) begin n_bad++;
      $display("FAIL rm_outs: got txd=%h txv=%b stb=%b wa=%h err=%b want all 0", tx_data_o, tx_valid_o, wr_stb_o, wr_addr_o, err_o); end
    cyc(1'b0, 1'b1, 8'h03, 1'b0);
    n_cmp++; if (wr_stb_o !== 1'b0) begin n_bad++; $display("FAIL rm_ptr_nostb: got %b want 0", wr_stb_o); end
    cyc(1'b0, 1'b1, 8'h44, 1'b0);
    n_cmp++; if ({wr_stb_o, wr_addr_o} !== {1'b1, 8'h03}) begin n_bad++; $display("FAIL rm_ptr: got %b/%h want 1/03", wr_stb_o, wr_addr_o); end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0; tx_req_i = 1'b0;
    exp_regs = 64'h0;
    test_reset();
    test_write_burst();
    test_read_back();
    test_id_oor();
    test_wrap();
    test_collisions();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
